// File: rtl/uart_tx_fifo_ctrl_pkg.sv
// Shared UART definitions: byte width, transmit-sequencer state encodings and
// the oversampling figures used to derive frame time.
package uart_tx_fifo_ctrl_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_OVERSAMPLE = 16;  // s_ticks per serial bit
  localparam int UART_FRAME_BITS = 10;  // start + 8 data + stop

  typedef logic [0:0] tx_state_t;

  localparam tx_state_t ST_IDLE = 1'b0;
  localparam tx_state_t ST_WAIT = 1'b1;

  function automatic int frame_ticks();
    return UART_FRAME_BITS * UART_OVERSAMPLE;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_ctrl_sync_fifo.sv
// Synchronous byte FIFO with separate occupancy count and a sticky overflow
// flag. Read data is the entry at the read pointer, valid whenever not empty.
module uart_sync_fifo
  import uart_tx_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  input  logic              clr_overflow,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic              overflow_reg;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign overflow = overflow_reg;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_data = mem[rd_ptr_reg];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + (ADDR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (ADDR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
      // A write against a full FIFO is dropped; setting beats clearing.
      if (push & full) begin
        overflow_reg <= 1'b1;
      end else if (clr_overflow) begin
        overflow_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Feeds buffered bytes into the UART transmitter one frame at a time,
// waiting for the transmitter's done tick before launching the next byte.
module uart_tx_fifo_ctrl
  import uart_tx_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_overflow,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_din,
  input  logic              tx_done_tick,
  output logic              busy
);

  tx_state_t         state_reg;
  logic              tx_start_reg;
  logic [DATA_W-1:0] tx_din_reg;
  logic [DATA_W-1:0] rd_data;
  logic              pop;

  assign pop      = (state_reg == ST_IDLE) & ~empty;
  assign busy     = (state_reg == ST_WAIT);
  assign tx_start = tx_start_reg;
  assign tx_din   = tx_din_reg;

  uart_sync_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push         (wr),
    .wr_data      (wr_data),
    .pop          (pop),
    .rd_data      (rd_data),
    .clr_overflow (clr_overflow),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      tx_start_reg <= 1'b0;
      tx_din_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!empty) begin
            tx_din_reg   <= rd_data;
            tx_start_reg <= 1'b1;
            state_reg    <= ST_WAIT;
          end else begin
            tx_start_reg <= 1'b0;
          end
        end
        default: begin
          // tx_din stays put for the whole frame.
          tx_start_reg <= 1'b0;
          if (tx_done_tick) state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Scoreboard bench for uart_tx_fifo_ctrl with a behavioural transmitter that
// shifts out a 10-bit frame at 16 ticks per bit and can be held mid-frame.
module tb_uart_tx_fifo_ctrl;
  import uart_tx_fifo_ctrl_pkg::*;

  localparam int ADDR_W      = 4;
  localparam int DATA_W      = 8;
  localparam int FRAME_TICKS = UART_FRAME_BITS * UART_OVERSAMPLE;

  localparam int K_EMPTY = 0, K_FULL = 1, K_COUNT = 2, K_OVF = 3, K_START = 4;
  localparam int K_DIN = 5, K_BUSY = 6, K_WAIT = 7, K_FRAME = 8, K_SBQ = 9;

  logic              clock;
  logic              reset;
  logic              wr;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              clr_overflow;
  logic              tx_start;
  logic [DATA_W-1:0] tx_din;
  logic              tx_done_tick;
  logic              busy;

  uart_tx_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .wr           (wr),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard storage: stimulus appends, monitor consumes.
  int          st_kind [1024];
  logic [31:0] st_exp  [1024];
  int          st_wr = 0;
  int          st_rd = 0;
  logic [7:0]  exp_byte [256];
  int          eb_wr = 0;
  int          eb_rd = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        wait_ok = 1'b1;

  // Transmitter model.
  logic        tx_block = 1'b0;
  logic        tx_active;
  int          tx_cnt;
  logic [9:0]  tx_frame;
  logic [9:0]  cap_reg;

  always @(posedge clock) begin
    if (reset) begin
      tx_active    <= 1'b0;
      tx_done_tick <= 1'b0;
      tx_cnt       <= 0;
    end else begin
      tx_done_tick <= 1'b0;
      if (tx_start) begin
        tx_active <= 1'b1;
        tx_cnt    <= 0;
        tx_frame  <= {1'b1, tx_din, 1'b0};
        cap_reg   <= '0;
      end else if (tx_active && !tx_block) begin
        if (tx_cnt % 16 == 8) cap_reg <= {tx_frame[tx_cnt / 16], cap_reg[9:1]};
        if (tx_cnt == FRAME_TICKS - 1) begin
          tx_active    <= 1'b0;
          tx_done_tick <= 1'b1;
        end
        tx_cnt <= tx_cnt + 1;
      end
    end
  end

  // Monitor: drains pending status checks and checks every start pulse.
  logic start_prev = 1'b0;
  always @(negedge clock) begin
    logic [31:0] act;
    string       nm;
    while (st_rd < st_wr) begin
      case (st_kind[st_rd])
        K_EMPTY: begin act = 32'(empty);     nm = "empty";     end
        K_FULL:  begin act = 32'(full);      nm = "full";      end
        K_COUNT: begin act = 32'(count);     nm = "count";     end
        K_OVF:   begin act = 32'(overflow);  nm = "overflow";  end
        K_START: begin act = 32'(tx_start);  nm = "tx_start";  end
        K_DIN:   begin act = 32'(tx_din);    nm = "tx_din";    end
        K_BUSY:  begin act = 32'(busy);      nm = "busy";      end
        K_WAIT:  begin act = 32'(wait_ok);   nm = "wait_bound"; end
        K_FRAME: begin act = 32'(cap_reg);   nm = "serial_frame"; end
        default: begin act = 32'(eb_wr - eb_rd); nm = "bytes_outstanding"; end
      endcase
      n_checks++;
      if (act !== st_exp[st_rd]) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, st_exp[st_rd], $time);
      end
      st_rd++;
    end
    if (!reset && tx_start) begin
      n_checks++;
      if (eb_rd >= eb_wr) begin
        n_fail++;
        $display("FAIL tx_byte: got 0x%02h, expected no start pulse at %0t", tx_din, $time);
      end else begin
        $display("tx byte 0x%02h (expected 0x%02h) at %0t", tx_din, exp_byte[eb_rd], $time);
        if (tx_din !== exp_byte[eb_rd]) begin
          n_fail++;
          $display("FAIL tx_byte: got 0x%02h, expected 0x%02h", tx_din, exp_byte[eb_rd]);
        end
        eb_rd++;
      end
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_at_start: got %0b, expected 1", busy);
      end
      n_checks++;
      if (start_prev !== 1'b0) begin
        n_fail++;
        $display("FAIL start_width: previous cycle tx_start got %0b, expected 0", start_prev);
      end
    end
    start_prev <= tx_start;
  end

  task automatic expect_st(input int k, input logic [31:0] v);
    st_kind[st_wr] = k;
    st_exp[st_wr]  = v;
    st_wr++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b, input bit accept);
    wr      = 1'b1;
    wr_data = b;
    if (accept) begin
      exp_byte[eb_wr] = b;
      eb_wr++;
    end
    tick();
    wr = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while ((busy || !empty || tx_active) && n < max_cycles) begin
      tick();
      n++;
    end
    wait_ok = (n < max_cycles);
    expect_st(K_WAIT, 1);
  endtask

  task automatic wait_done(input int max_cycles);
    int n = 0;
    while (tx_done_tick !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    wait_ok = (n < max_cycles);
    expect_st(K_WAIT, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr = 1'b0; wr_data = '0; clr_overflow = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state held while idle.
    for (int i = 0; i < 20; i++) begin
      tick();
      expect_st(K_EMPTY, 1); expect_st(K_FULL, 0); expect_st(K_COUNT, 0);
      expect_st(K_START, 0); expect_st(K_DIN, 0);  expect_st(K_BUSY, 0);
      expect_st(K_OVF, 0);
    end

    // Single byte: start pulse one edge after the write edge.
    write_byte(8'hA5, 1);
    expect_st(K_COUNT, 1); expect_st(K_START, 0);
    tick();
    expect_st(K_START, 1); expect_st(K_DIN, 32'hA5); expect_st(K_BUSY, 1); expect_st(K_EMPTY, 1);
    tick();
    expect_st(K_START, 0); expect_st(K_DIN, 32'hA5); expect_st(K_BUSY, 1);
    wait_idle(400);
    expect_st(K_FRAME, 32'b1101001010); expect_st(K_BUSY, 0); expect_st(K_EMPTY, 1);

    // Burst of three: back-to-back starts one edge after each done edge.
    write_byte(8'h01, 1);
    write_byte(8'h02, 1);
    expect_st(K_COUNT, 1);
    write_byte(8'h03, 1);
    expect_st(K_COUNT, 2);
    for (int i = 0; i < 2; i++) begin
      wait_done(400);
      tick();
      expect_st(K_BUSY, 0); expect_st(K_START, 0);
      tick();
      expect_st(K_START, 1); expect_st(K_DIN, 32'(i + 2));
    end
    wait_idle(400);

    // Fill with the transmitter stalled, then overflow and clear.
    tx_block = 1'b1;
    for (int b = 8'h10; b <= 8'h20; b++) write_byte(8'(b), 1);
    expect_st(K_COUNT, 16); expect_st(K_FULL, 1); expect_st(K_OVF, 0);
    expect_st(K_DIN, 32'h10); expect_st(K_BUSY, 1); expect_st(K_EMPTY, 0);
    write_byte(8'h21, 0);
    expect_st(K_OVF, 1); expect_st(K_COUNT, 16); expect_st(K_FULL, 1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    expect_st(K_OVF, 0); expect_st(K_COUNT, 16);
    clr_overflow = 1'b1;
    write_byte(8'h22, 0);
    expect_st(K_OVF, 1);
    tick();
    clr_overflow = 1'b0;
    expect_st(K_OVF, 0);
    tx_block = 1'b0;
    wait_idle(4000);
    expect_st(K_EMPTY, 1); expect_st(K_FULL, 0);

    // Forty bytes in groups of ten across pointer wrap.
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 10; k++) write_byte(8'(g * 10 + k), 1);
      wait_idle(2000);
    end
    expect_st(K_EMPTY, 1);

    // Reset mid-frame discards the two still-buffered bytes.
    tx_block = 1'b1;
    write_byte(8'h61, 1);
    write_byte(8'h62, 0);
    write_byte(8'h63, 0);
    expect_st(K_BUSY, 1); expect_st(K_COUNT, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tx_block = 1'b0;
    expect_st(K_COUNT, 0); expect_st(K_BUSY, 0); expect_st(K_EMPTY, 1); expect_st(K_START, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_st(K_START, 0); expect_st(K_COUNT, 0);
    end
    write_byte(8'h55, 1);
    tick();
    expect_st(K_START, 1); expect_st(K_DIN, 32'h55);
    wait_idle(400);
    expect_st(K_SBQ, 0);

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_ctrl.md
Name: uart_tx_fifo_ctrl

Overview:
Upstream feeder for the UART transmitter. Buffers bytes written by the processor/debug unit in a small FIFO and sequences them into the transmitter, one byte per frame.
- Drives the transmitter's tx_start and din inputs.
- Waits on the transmitter's tx_done_tick before issuing the next byte.
- Provides full/empty/count/overflow status for software polling.

Parameters:
ADDR_W, 4, FIFO address width; depth = 2**ADDR_W entries (default 16)
DATA_W, 8, byte width; must match the transmitter din width

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
wr  in  1  write strobe; one byte pushed per cycle while high and not full
wr_data  in  DATA_W  byte to push, sampled when wr=1
full  out  1  FIFO holds 2**ADDR_W entries
empty  out  1  FIFO holds 0 entries
count  out  ADDR_W+1  number of entries currently stored
overflow  out  1  sticky: a write was attempted while full
clr_overflow  in  1  clears overflow
tx_start  out  1  one-cycle start pulse to transmitter
tx_din  out  DATA_W  byte presented to transmitter; held stable from the tx_start pulse until the next pulse
tx_done_tick  in  1  one-cycle completion pulse from transmitter (end of stop bit)
busy  out  1  a frame is in flight (FSM in WAIT)

Behaviour:
- Reset (synchronous, active-high):
  - wr_ptr, rd_ptr and count = 0; empty=1, full=0.
  - overflow=0, tx_start=0, tx_din=0, busy=0, FSM=IDLE.
  - Memory contents are not reset.
- Reset mid-frame: the FSM returns to IDLE and all buffered bytes are discarded. The transmitter shares the same reset, so no done handshake is expected afterwards.
- Storage: register array, 2**ADDR_W x DATA_W. Pointers are ADDR_W bits and wrap naturally modulo depth. count is tracked separately, which disambiguates full from empty.
- Push:
  - Condition: wr & ~full, with full taken as the pre-edge value.
  - Action: mem[wr_ptr] <= wr_data; wr_ptr++.
- Overflow:
  - wr & full: the write is dropped and overflow <= 1.
  - The write is dropped even if a pop occurs in the same cycle.
  - clr_overflow clears overflow; a simultaneous set wins over clear.
- Pop: occurs only in the IDLE->WAIT transition (see FSM).
- count: +1 on push only, -1 on pop only, unchanged when push and pop occur in the same cycle.
- full, empty, count and busy are registered or decoded from registers; there are no combinational paths from inputs.
- FSM with 2 states:
  - IDLE:
    - busy=0.
    - If ~empty: tx_din <= mem[rd_ptr], rd_ptr++, tx_start <= 1, go to WAIT.
    - Otherwise stay in IDLE with tx_start=0.
  - WAIT:
    - busy=1; tx_start <= 0, so the pulse is exactly 1 cycle; tx_din is held.
    - On tx_done_tick, go to IDLE.
    - tx_done_tick is ignored while in IDLE.
- Latency: with the FIFO empty and the FSM in IDLE, wr at edge N sets count=1 at edge N. tx_start is high and tx_din valid after edge N+1.
- Back-to-back: tx_done_tick at edge D returns the FSM to IDLE. tx_start for the next byte is high after edge D+1. The transmitter is already in its idle state then, so no extra spacing is needed.
- Simultaneous push and pop in IDLE with count=1: both succeed, count stays 1, and the new byte is sent next.
- Width rule: count ranges 0..2**ADDR_W, so it needs ADDR_W+1 bits.

Decomposition:
- Shared UART package:
  - DATA_W default (8).
  - FSM state encodings (IDLE=1'b0, WAIT=1'b1).
  - The oversampling constant (16 ticks/bit), used by benches to compute frame time = 10 bytes-bits x 16 s_ticks.
- One natural sub-module: uart_sync_fifo.
  - Contents: memory, pointers, count, full/empty and overflow.
  - Interface: push/pop strobes and rd_data.
  - The top level holds the FSM and the tx_din/tx_start registers.

Test Plan:
- Reset then idle: after reset, empty=1, full=0, count=0, tx_start=0, tx_din=0, busy=0 for 20 cycles with no writes.
- Single byte:
  - Stimulus: write 0xA5 at edge N.
  - Required: tx_start high for exactly 1 cycle after edge N+1 with tx_din=0xA5; busy=1.
  - Required: after the transmitter raises tx_done_tick (serial line shows 0,1,0,1,0,0,1,0,1 then stop 1), busy=0 and empty=1.
- Burst and order: write 0x01,0x02,0x03 on consecutive cycles -> count peaks at 2 or 3. Three tx_start pulses occur, each 1 cycle after the previous tx_done_tick edge, carrying tx_din 0x01,0x02,0x03 in order.
- Full/overflow:
  - Stimulus: with the transmitter idle-blocked (tx_done_tick held 0 after the first start), write 17 bytes 0x10..0x20.
  - Required: first byte popped to tx_din=0x10, then 16 stored, full=1, count=16.
  - Stimulus: an 18th write of 0x21.
  - Required: overflow=1, count unchanged; clr_overflow -> overflow=0.
- Pointer wrap: push and drain 40 bytes 0x00..0x27 in groups of 10 -> tx_din sequence is exact, with no duplication or loss across the rd_ptr/wr_ptr wrap at 16.
- Reset mid-frame: 3 bytes queued and busy=1, then reset for 1 cycle -> count=0, busy=0, tx_start stays 0; the next write 0x55 is transmitted normally.
